// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the fpga_cfg_loader configuration sequencer.
package fpga_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CRC,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam int unsigned TRAILER_BYTES = 2;

  // One bit-serial CRC-16-CCITT step, MSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/fpga_cfg_crc16.sv
// Bit-serial CRC-16-CCITT accumulator over the configuration bits.
module fpga_cfg_crc16
  import fpga_cfg_pkg::*;
(
  input  logic        prog_clk,
  input  logic        prog_reset,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  // Next CRC: clear wins over update.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, din);
    end
  end

  // CRC register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) crc_q <= CRC_INIT;
    else            crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration sequencer: streams a byte-wide bitstream serially into the
// fabric configuration chain, then releases isolation and reset in order.
// Optional CRC-16 trailer check is compiled in with FPGA_CFG_CRC_EN.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN     = 4096,
  parameter int unsigned RELEASE_DELAY = 16
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_clk_en,
  output logic       isol_n,
  output logic       fabric_reset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RW = $clog2(RELEASE_DELAY + 1);

  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [3:0]      vcnt_q, vcnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [RW-1:0]   rel_cnt_q, rel_cnt_d;
  logic            s_ready_q, s_ready_d;
  logic            head_q, head_d;
  logic            clk_en_q, clk_en_d;
  logic            isol_n_q, isol_n_d;
  logic            fab_rst_q, fab_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_c;
  logic [31:0]     rem_c;
  logic [3:0]      nbits_c;

  assign accept_c = s_valid && s_ready_q;
  assign rem_c    = 32'(CHAIN_LEN) - 32'(acc_cnt_q);
  // Bits of the next byte that belong to the chain; the tail of the last byte is dropped.
  assign nbits_c  = (rem_c >= 32'd8) ? 4'd8 : 4'(rem_c);

`ifdef FPGA_CFG_CRC_EN
  logic            error_q, error_d;
  logic            trl_cnt_q, trl_cnt_d;
  logic [7:0]      trl_hi_q, trl_hi_d;
  logic            crc_clr_c;
  logic [15:0]     crc_c;

  fpga_cfg_crc16 u_crc (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clr        (crc_clr_c),
    .en         (clk_en_d),
    .din        (head_d),
    .crc        (crc_c)
  );
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    vcnt_d    = vcnt_q;
    bit_cnt_d = bit_cnt_q;
    acc_cnt_d = acc_cnt_q;
    rel_cnt_d = rel_cnt_q;
    s_ready_d = s_ready_q;
    head_d    = head_q;
    clk_en_d  = 1'b0;
    isol_n_d  = isol_n_q;
    fab_rst_d = fab_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef FPGA_CFG_CRC_EN
    error_d   = error_q;
    trl_cnt_d = trl_cnt_q;
    trl_hi_d  = trl_hi_q;
    crc_clr_c = 1'b0;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d   = ST_SHIFT;
          vcnt_d    = 4'd0;
          bit_cnt_d = '0;
          acc_cnt_d = '0;
          s_ready_d = 1'b1;
          isol_n_d  = 1'b0;
          fab_rst_d = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
`ifdef FPGA_CFG_CRC_EN
          error_d   = 1'b0;
          trl_cnt_d = 1'b0;
          crc_clr_c = 1'b1;
`endif
        end
      end

      ST_SHIFT: begin
        if (bit_cnt_q == BW'(CHAIN_LEN)) begin
`ifdef FPGA_CFG_CRC_EN
          state_d   = ST_CRC;
          s_ready_d = 1'b1;
`else
          state_d   = ST_RELEASE;
          s_ready_d = 1'b0;
          isol_n_d  = 1'b1;
          rel_cnt_d = '0;
`endif
        end else begin
          if (vcnt_q != 4'd0) begin
            head_d    = sr_q[7];
            sr_d      = {sr_q[6:0], 1'b0};
            vcnt_d    = vcnt_q - 4'd1;
            clk_en_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end else if (accept_c) begin
            head_d    = s_data[7];
            sr_d      = {s_data[6:0], 1'b0};
            vcnt_d    = nbits_c - 4'd1;
            clk_en_d  = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            acc_cnt_d = acc_cnt_q + BW'(nbits_c);
          end
          s_ready_d = (vcnt_d == 4'd0) && (32'(acc_cnt_d) < CHAIN_LEN);
        end
      end

`ifdef FPGA_CFG_CRC_EN
      ST_CRC: begin
        if (accept_c) begin
          if (!trl_cnt_q) begin
            trl_hi_d  = s_data;
            trl_cnt_d = 1'b1;
          end else begin
            s_ready_d = 1'b0;
            if ({trl_hi_q, s_data} == crc_c) begin
              state_d   = ST_RELEASE;
              isol_n_d  = 1'b1;
              rel_cnt_d = '0;
            end else begin
              state_d   = ST_ERROR;
              error_d   = 1'b1;
              busy_d    = 1'b0;
              isol_n_d  = 1'b0;
              fab_rst_d = 1'b1;
            end
          end
        end
      end
`endif

      ST_RELEASE: begin
        if (rel_cnt_q == RW'(RELEASE_DELAY - 1)) begin
          state_d   = ST_DONE;
          fab_rst_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          rel_cnt_d = rel_cnt_q + RW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      vcnt_q    <= '0;
      bit_cnt_q <= '0;
      acc_cnt_q <= '0;
      rel_cnt_q <= '0;
      s_ready_q <= 1'b0;
      head_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      isol_n_q  <= 1'b0;
      fab_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      vcnt_q    <= vcnt_d;
      bit_cnt_q <= bit_cnt_d;
      acc_cnt_q <= acc_cnt_d;
      rel_cnt_q <= rel_cnt_d;
      s_ready_q <= s_ready_d;
      head_q    <= head_d;
      clk_en_q  <= clk_en_d;
      isol_n_q  <= isol_n_d;
      fab_rst_q <= fab_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef FPGA_CFG_CRC_EN
  // Trailer capture and error flag.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      error_q   <= 1'b0;
      trl_cnt_q <= 1'b0;
      trl_hi_q  <= '0;
    end else begin
      error_q   <= error_d;
      trl_cnt_q <= trl_cnt_d;
      trl_hi_q  <= trl_hi_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign s_ready      = s_ready_q;
  assign ccff_head    = head_q;
  assign ccff_clk_en  = clk_en_q;
  assign isol_n       = isol_n_q;
  assign fabric_reset = fab_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader (CHAIN_LEN=20, RELEASE_DELAY=4).
// Define FPGA_CFG_CRC_EN to also exercise the CRC trailer path.
module tb_fpga_cfg_loader;

  localparam int unsigned CL = 20;
  localparam int unsigned RD = 4;
  localparam logic [19:0] EXP_BITS = 20'b1010_0101_0011_1100_1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, ccff_head, ccff_clk_en, isol_n, fabric_reset, busy, done, error;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int bits_seen = 0;
  int last_cyc = 0;
  logic exp_q[$];

  fpga_cfg_loader #(.CHAIN_LEN(CL), .RELEASE_DELAY(RD)) dut (
    .prog_clk     (clk),
    .prog_reset   (rst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_clk_en  (ccff_clk_en),
    .isol_n       (isol_n),
    .fabric_reset (fabric_reset),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every enabled chain bit is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && ccff_clk_en) begin
      bits_seen++;
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_chain_bit: got bit %0b with empty scoreboard (cycle %0d)", ccff_head, cyc);
      end else begin
        check("ccff_head", 32'(ccff_head), 32'(exp_q.pop_front()));
      end
    end
  end

`ifdef FPGA_CFG_CRC_EN
  function automatic logic [15:0] crc_model(input logic [19:0] bits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 19; i >= 0; i--) begin
      fb = bits[i] ^ c[15];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  // Entered at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    s_data = b;
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles expected 1", t);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_load(input bit gap, input bit mid_start, input bit bad_crc);
    int s_cyc;
    int base;
    int t;
    logic [7:0] bytes_a [3];
    bytes_a = '{8'hA5, 8'h3C, 8'hF0};
    for (int i = 0; i < 20; i++) exp_q.push_back(EXP_BITS[19-i]);
    base = bits_seen;
    pulse_start();
    s_cyc = cyc;
    check("start_busy", 32'(busy), 1);
    check("start_isol_n", 32'(isol_n), 0);
    check("start_fabric_reset", 32'(fabric_reset), 1);
    check("start_done_clr", 32'(done), 0);
    check("start_error_clr", 32'(error), 0);
    for (int k = 0; k < 3; k++) begin
      send_byte(bytes_a[k]);
      if (k == 0 && mid_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (k == 0 && gap) begin
        s_valid = 1'b0;
        t = 0;
        while (!s_ready && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int g = 0; g < 5; g++) begin
          @(negedge clk);
          check("gap_clk_en", 32'(ccff_clk_en), 0);
        end
      end
    end
    s_valid = 1'b0;
    check("ready_low_after_last", 32'(s_ready), 0);
`ifdef FPGA_CFG_CRC_EN
    begin
      logic [15:0] trl;
      trl = crc_model(EXP_BITS) ^ (bad_crc ? 16'h0010 : 16'h0000);
      send_byte(trl[15:8]);
      send_byte(trl[7:0]);
      s_valid = 1'b0;
    end
`endif
    t = 0;
    while (!isol_n && !error && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bits_shifted", 32'(bits_seen - base), 20);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    if (!gap) check("last_bit_cycle", 32'(last_cyc), 32'(s_cyc + 20));
    if (bad_crc) begin
      check("err_error", 32'(error), 1);
      check("err_isol_n", 32'(isol_n), 0);
      check("err_fabric_reset", 32'(fabric_reset), 1);
      check("err_busy", 32'(busy), 0);
      check("err_done", 32'(done), 0);
    end else begin
      check("isol_n_rise", 32'(isol_n), 1);
`ifndef FPGA_CFG_CRC_EN
      check("isol_n_cycle", 32'(cyc), 32'(last_cyc + 1));
`endif
      repeat (RD - 1) @(negedge clk);
      check("release_hold_reset", 32'(fabric_reset), 1);
      check("release_hold_done", 32'(done), 0);
      @(negedge clk);
      check("done_fabric_reset", 32'(fabric_reset), 0);
      check("done_done", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_error", 32'(error), 0);
      check("done_isol_n", 32'(isol_n), 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_ccff_head"}, 32'(ccff_head), 0);
    check({tag, "_ccff_clk_en"}, 32'(ccff_clk_en), 0);
    check({tag, "_isol_n"}, 32'(isol_n), 0);
    check({tag, "_fabric_reset"}, 32'(fabric_reset), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    int t;
    // Reset with s_valid asserted: nothing may be accepted.
    s_valid = 1'b1;
    s_data = 8'hA5;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 0);
    end
    s_valid = 1'b0;

    do_load(1'b0, 1'b0, 1'b0);
    do_load(1'b1, 1'b0, 1'b0);

    // prog_reset after 10 bits, then a clean reload from bit 0.
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(EXP_BITS[19-i]);
    t = bits_seen;
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h3C);
    s_valid = 1'b0;
    for (int w = 0; w < 100 && (bits_seen - t) < 10; w++) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_bits", 32'(bits_seen - t), 10);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_load(1'b0, 1'b1, 1'b0);
`ifdef FPGA_CFG_CRC_EN
    do_load(1'b0, 1'b0, 1'b1);
    do_load(1'b0, 1'b0, 1'b0);
`endif
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
